// File: rtl/mining_pkg.sv
// Package: mining_pkg
// Purpose: shared sizing constants and FSM state encoding for the block loader
//          that feeds the mining core.
// Contents:
//   BLOCK_BYTES  header bytes per job
//   TARGET_W     target width
//   NONCE_W      nonce width
//   BLOCK_W      assembled header width (8 bits per header byte)
//   CNT_W        width of the header byte counter
//   state_t      loader FSM states (the unused code 2'd3 falls back to ST_LOAD)
package mining_pkg;

    localparam int BLOCK_BYTES = 12;
    localparam int TARGET_W    = 8;
    localparam int NONCE_W     = 32;
    localparam int BLOCK_W     = 8 * BLOCK_BYTES;
    localparam int CNT_W       = $clog2(BLOCK_BYTES);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/block_loader_if.sv
// Interface: block_loader_if
// Purpose: groups the two handshakes the loader exposes to the rest of the
//          system: the header byte stream (byte_in/byte_valid/byte_ready) and
//          the nonce result port (nonce_out/result_valid/result_ack).
// Modports:
//   master  the producer/consumer side: drives bytes and the acknowledge
//   slave   the loader side: drives byte_ready and the result
interface block_loader_if;
    import mining_pkg::*;

    logic [7:0]         byte_in;
    logic               byte_valid;
    logic               byte_ready;
    logic [NONCE_W-1:0] nonce_out;
    logic               result_valid;
    logic               result_ack;

    modport master (
        output byte_in, byte_valid, result_ack,
        input  byte_ready, nonce_out, result_valid
    );

    modport slave (
        input  byte_in, byte_valid, result_ack,
        output byte_ready, nonce_out, result_valid
    );

endinterface

// File: rtl/block_loader.sv
// Module: block_loader
// Purpose: collects a BLOCK_BYTES-byte header one byte per cycle, latches a
//          target, holds start to the mining core until it reports terminado,
//          then offers the captured nonce on a valid/ack port.
// Ports:
//   clk         system clock, all state changes on posedge
//   reset       asynchronous, active-high reset
//   bus         block_loader_if.slave: byte stream in, nonce result out
//   target_in   target value, latched by target_we while loading
//   target_we   target write strobe (ignored outside loading)
//   block_out   assembled header to the core
//   target_out  latched target to the core
//   start       level start to the core, high for the whole run
//   terminado   core done indication
//   nonce_in    core nonce, captured when terminado is seen
//   busy        high while a job is running or its result is pending
module block_loader
    import mining_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    block_loader_if.slave       bus,
    input  logic [TARGET_W-1:0] target_in,
    input  logic                target_we,
    output logic [BLOCK_W-1:0]  block_out,
    output logic [TARGET_W-1:0] target_out,
    output logic                start,
    input  logic                terminado,
    input  logic [NONCE_W-1:0]  nonce_in,
    output logic                busy
);

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BLOCK_W-1:0]  block_q, block_d;
    logic [TARGET_W-1:0] target_q, target_d;
    logic [NONCE_W-1:0]  nonce_q, nonce_d;

    logic accept;
    logic last_byte;

    // byte_ready is a flop rather than a decode of the state so that it stays
    // low while reset is held and only rises on the first edge after release.
    assign accept    = bus.byte_valid && ready_q && (state_q == ST_LOAD);
    assign last_byte = (cnt_q == CNT_W'(BLOCK_BYTES - 1));

    // State and datapath registers; reset returns every job-related value to
    // zero so a partially loaded header is thrown away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_LOAD;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
            block_q  <= '0;
            target_q <= '0;
            nonce_q  <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            cnt_q    <= cnt_d;
            block_q  <= block_d;
            target_q <= target_d;
            nonce_q  <= nonce_d;
        end
    end

    // Next-state logic. The last header byte moves straight to RUN on its own
    // accept edge, so start rises with zero extra latency. The spare state
    // code falls back to LOAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (accept && last_byte) state_d = ST_RUN;
            ST_RUN:  if (terminado)           state_d = ST_DONE;
            ST_DONE: if (bus.result_ack)      state_d = ST_LOAD;
            default:                          state_d = ST_LOAD;
        endcase
        ready_d = (state_d == ST_LOAD);
    end

    // Datapath updates: byte write through an indexed part-select at the
    // current counter position, target latch while loading only, and nonce
    // capture on the edge where the core reports completion. The header is
    // kept after a job; the next job overwrites it byte by byte.
    always_comb begin
        cnt_d    = cnt_q;
        block_d  = block_q;
        target_d = target_q;
        nonce_d  = nonce_q;
        if (accept) begin
            block_d[{cnt_q, 3'b000} +: 8] = bus.byte_in;
            cnt_d = last_byte ? '0 : cnt_q + CNT_W'(1);
        end
        if ((state_q == ST_LOAD) && target_we) begin
            target_d = target_in;
        end
        if ((state_q == ST_RUN) && terminado) begin
            nonce_d = nonce_in;
        end
    end

    // Outputs come only from flops or the state decode, never from inputs.
    always_comb begin
        start            = (state_q == ST_RUN);
        busy             = (state_q == ST_RUN) || (state_q == ST_DONE);
        bus.result_valid = (state_q == ST_DONE);
        bus.byte_ready   = ready_q;
        bus.nonce_out    = nonce_q;
        block_out        = block_q;
        target_out       = target_q;
    end

endmodule

// File: tb/tb_block_loader.sv
// Testbench: tb_block_loader
// Purpose: directed and randomized jobs through block_loader. The bench keeps
//          its own picture of the job (the header bytes written so far, the
//          target and the last nonce) and compares the DUT against it after
//          every clock step, one cycle at a time.
module tb_block_loader;
    import mining_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic [TARGET_W-1:0] target_in;
    logic                target_we;
    logic [BLOCK_W-1:0]  block_out;
    logic [TARGET_W-1:0] target_out;
    logic                start;
    logic                terminado;
    logic [NONCE_W-1:0]  nonce_in;
    logic                busy;

    block_loader_if bus_if ();

    block_loader dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if.slave),
        .target_in  (target_in),
        .target_we  (target_we),
        .block_out  (block_out),
        .target_out (target_out),
        .start      (start),
        .terminado  (terminado),
        .nonce_in   (nonce_in),
        .busy       (busy)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int load_cycles;

    logic [7:0]         job         [BLOCK_BYTES];
    logic [7:0]         model_bytes [BLOCK_BYTES];
    logic [7:0]         exp_target;
    logic [NONCE_W-1:0] exp_nonce;

    // Safety net so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    // Header the bench expects: byte k sits in bits [8k+7:8k].
    function automatic logic [BLOCK_W-1:0] model_block();
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int k = 0; k < BLOCK_BYTES; k++) r[8*k +: 8] = model_bytes[k];
        return r;
    endfunction

    task automatic check(input string tag, input logic [BLOCK_W-1:0] obs,
                         input logic [BLOCK_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 unit after the edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_load(input string tag);
        check({tag, "_ready"}, 96'(bus_if.byte_ready), 96'(1));
        check({tag, "_start"}, 96'(start), 96'(0));
        check({tag, "_busy"},  96'(busy), 96'(0));
        check({tag, "_valid"}, 96'(bus_if.result_valid), 96'(0));
    endtask

    // Stream job[] into the loader. stall_mode: 0 back-to-back, 1 an idle
    // cycle before every byte, 2 random idle cycles.
    task automatic load_job(input int stall_mode, input bit do_tgt,
                            input logic [7:0] tgt);
        load_cycles = 0;
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            bit stall;
            stall = (stall_mode == 1) || (stall_mode == 2 && $urandom_range(0, 1) == 1);
            if (stall) begin
                bus_if.byte_valid = 1'b0;
                bus_if.byte_in    = 8'($urandom);
                tick();
                load_cycles++;
                check("stall_no_write", block_out, model_block());
                check("stall_start", 96'(start), 96'(0));
            end
            bus_if.byte_valid = 1'b1;
            bus_if.byte_in    = job[k];
            if (do_tgt && k == 0) begin
                target_we = 1'b1;
                target_in = tgt;
            end
            tick();
            load_cycles++;
            target_we      = 1'b0;
            model_bytes[k] = job[k];
            if (do_tgt && k == 0) exp_target = tgt;
            check("load_block", block_out, model_block());
            check("load_target", 96'(target_out), 96'(exp_target));
            if (k < BLOCK_BYTES - 1) begin
                check("load_ready", 96'(bus_if.byte_ready), 96'(1));
                check("load_start", 96'(start), 96'(0));
            end else begin
                check("run_start", 96'(start), 96'(1));
                check("run_ready", 96'(bus_if.byte_ready), 96'(0));
                check("run_busy",  96'(busy), 96'(1));
            end
        end
        bus_if.byte_valid = 1'b0;
    endtask

    // Let the core run for 'latency' cycles (while poking inputs that must be
    // ignored), finish with 'nonce', then acknowledge after 'ack_delay' cycles.
    task automatic finish_job(input int latency, input logic [NONCE_W-1:0] nonce,
                              input int ack_delay);
        for (int i = 0; i < latency; i++) begin
            terminado         = 1'b0;
            nonce_in          = $urandom;
            bus_if.byte_valid = 1'b1;
            bus_if.byte_in    = 8'($urandom);
            target_we         = 1'b1;
            target_in         = 8'h55;
            tick();
            check("running_start",  96'(start), 96'(1));
            check("running_valid",  96'(bus_if.result_valid), 96'(0));
            check("running_block",  block_out, model_block());
            check("running_target", 96'(target_out), 96'(exp_target));
        end
        bus_if.byte_valid = 1'b0;
        target_we         = 1'b0;
        terminado         = 1'b1;
        nonce_in          = nonce;
        tick();
        terminado = 1'b0;
        nonce_in  = $urandom;
        exp_nonce = nonce;
        check("done_start", 96'(start), 96'(0));
        check("done_valid", 96'(bus_if.result_valid), 96'(1));
        check("done_nonce", 96'(bus_if.nonce_out), 96'(exp_nonce));
        check("done_busy",  96'(busy), 96'(1));
        check("done_ready", 96'(bus_if.byte_ready), 96'(0));
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            check("hold_valid", 96'(bus_if.result_valid), 96'(1));
            check("hold_nonce", 96'(bus_if.nonce_out), 96'(exp_nonce));
        end
        bus_if.result_ack = 1'b1;
        tick();
        bus_if.result_ack = 1'b0;
        check_idle_load("acked");
        check("acked_nonce", 96'(bus_if.nonce_out), 96'(exp_nonce));
        check("acked_block", block_out, model_block());
    endtask

    task automatic random_job();
        for (int k = 0; k < BLOCK_BYTES; k++) job[k] = 8'($urandom);
    endtask

    initial begin
        reset             = 1'b1;
        target_in         = '0;
        target_we         = 1'b0;
        terminado         = 1'b0;
        nonce_in          = '0;
        bus_if.byte_in    = '0;
        bus_if.byte_valid = 1'b0;
        bus_if.result_ack = 1'b0;
        for (int k = 0; k < BLOCK_BYTES; k++) model_bytes[k] = 8'h00;
        exp_target = 8'h00;
        exp_nonce  = '0;

        // Reset values, then byte_ready one cycle after release
        tick();
        tick();
        check("rst_block",  block_out, 96'(0));
        check("rst_target", 96'(target_out), 96'(0));
        check("rst_nonce",  96'(bus_if.nonce_out), 96'(0));
        check("rst_ready",  96'(bus_if.byte_ready), 96'(0));
        check("rst_start",  96'(start), 96'(0));
        reset = 1'b0;
        check("release_ready", 96'(bus_if.byte_ready), 96'(0));
        tick();
        check_idle_load("post_reset");

        // Back-to-back load of the reference header with target 0x0A
        job = '{8'h61, 8'h69, 8'h63, 8'h70, 8'h21, 8'h00,
                8'h00, 8'h03, 8'h17, 8'h08, 8'h00, 8'hf3};
        load_job(0, 1'b1, 8'h0A);
        check("b2b_cycles", 96'(load_cycles), 96'(BLOCK_BYTES));
        check("b2b_block",  block_out, 96'hf30008170300002170636961);
        check("b2b_target", 96'(target_out), 96'(8'h0A));

        // Finish with nonce 0x1234, ack held off 5 cycles; target writes in RUN ignored
        finish_job(3, 32'h0000_1234, 5);
        check("ignored_target", 96'(target_out), 96'(8'h0A));

        // terminado and result_ack while loading change nothing
        terminado         = 1'b1;
        bus_if.result_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle_load("load_ignore");
        end
        terminado         = 1'b0;
        bus_if.result_ack = 1'b0;

        // A random job so the next header differs from what is stored
        random_job();
        load_job(0, 1'b1, 8'($urandom));
        finish_job(1, $urandom, 0);

        // Stalled load of the reference header: one idle cycle per byte
        job = '{8'h61, 8'h69, 8'h63, 8'h70, 8'h21, 8'h00,
                8'h00, 8'h03, 8'h17, 8'h08, 8'h00, 8'hf3};
        load_job(1, 1'b1, 8'h0A);
        check("stall_cycles", 96'(load_cycles), 96'(2 * BLOCK_BYTES));
        check("stall_block",  block_out, 96'hf30008170300002170636961);
        finish_job(0, $urandom, 0);

        // Abort after 5 bytes with an asynchronous mid-cycle reset
        random_job();
        for (int k = 0; k < 5; k++) begin
            bus_if.byte_valid = 1'b1;
            bus_if.byte_in    = job[k];
            tick();
            model_bytes[k] = job[k];
        end
        bus_if.byte_valid = 1'b0;
        check("partial_block", block_out, model_block());
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < BLOCK_BYTES; k++) model_bytes[k] = 8'h00;
        exp_target = 8'h00;
        exp_nonce  = '0;
        check("abort_block",  block_out, 96'(0));
        check("abort_target", 96'(target_out), 96'(0));
        check("abort_nonce",  96'(bus_if.nonce_out), 96'(0));
        check("abort_ready",  96'(bus_if.byte_ready), 96'(0));
        check("abort_busy",   96'(busy), 96'(0));
        tick();
        reset = 1'b0;
        tick();
        check_idle_load("abort_release");

        // Reload after abort must start again from byte 0
        job = '{8'h61, 8'h69, 8'h63, 8'h70, 8'h21, 8'h00,
                8'h00, 8'h03, 8'h17, 8'h08, 8'h00, 8'hf3};
        load_job(0, 1'b1, 8'h0A);
        check("reload_block", block_out, 96'hf30008170300002170636961);
        finish_job(2, $urandom, 1);

        // Randomized jobs: random bytes, stalls, target, run length and ack delay
        for (int j = 0; j < 8; j++) begin
            random_job();
            load_job(2, ($urandom_range(0, 1) == 1), 8'($urandom));
            finish_job($urandom_range(0, 4), $urandom, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
